// File: rtl/clk_div_multi.sv
// clk_div_multi -- multi-channel, runtime-programmable clock divider.
//
// Each channel divides clk_in by a programmable ratio r (0 and 1 behave as 2).
// The divided clock stays low for ceil(r/2) cycles and then high for the rest
// of the period. A one-cycle tick marks the last cycle of every period. Ratio
// writes go to a shadow register and reach the counter only at a period
// boundary, so clk_out never glitches. A global sync pulse restarts every
// running channel at phase 0.
//
// Ports
//   clk_in    system clock, rising edge
//   rst_n     asynchronous active-low reset
//   ch_en     per-channel run enable (level)
//   sync      one-cycle pulse, restarts all running channels at phase 0
//   cfg_we    ratio write strobe
//   cfg_ch    channel addressed by the write (out-of-range writes are dropped)
//   cfg_div   new ratio
//   cfg_pend  per channel: ratio written but not yet applied
//   running   per channel: channel is counting (RUN or DRAIN)
//   clk_out   per channel: divided clock, registered
//   tick      per channel: high in the last cycle of each period, registered
//
// Channel FSM
//   state   | meaning
//   S_IDLE  | stopped, cnt held at 0, outputs low
//   S_RUN   | counting, enabled
//   S_DRAIN | enable dropped, finishing the current period, stops at the wrap

module clk_div_multi #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state, state_n;
        logic [DIV_W-1:0] cnt, cnt_n;
        logic [DIV_W-1:0] div_act, div_act_n;
        logic [DIV_W-1:0] shadow, shadow_n;
        logic             pend, pend_n;
        logic             clk_q, clk_n;
        logic             tick_q, tick_n;
        logic [DIV_W-1:0] r_cur, r_n;
        logic [DIV_W:0]   lo_n;
        logic             run_cur, run_n;
        logic             wrap, apply, wr_hit;

        // state register
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                div_act <= DIV_W'(DEF_DIV);
                shadow  <= DIV_W'(DEF_DIV);
                pend    <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                div_act <= div_act_n;
                shadow  <= shadow_n;
                pend    <= pend_n;
                clk_q   <= clk_n;
                tick_q  <= tick_n;
            end
        end

        // next-state logic
        always_comb begin
            state_n   = state;
            cnt_n     = cnt;
            run_cur   = (state != S_IDLE);
            r_cur     = (div_act < DIV_TWO) ? DIV_TWO : div_act;
            wrap      = run_cur && (cnt == r_cur - DIV_ONE);
            wr_hit    = cfg_we && (cfg_ch == CH_W'(i));
            apply     = (run_cur && (wrap || sync)) || ((state == S_IDLE) && pend);

            case (state)
                S_IDLE: begin
                    cnt_n = '0;
                    if (ch_en[i]) state_n = S_RUN;
                end
                S_RUN: begin
                    cnt_n = (sync || wrap) ? '0 : cnt + DIV_ONE;
                    // Enable dropped exactly on the last cycle: the period is
                    // already complete, so stop without another full period.
                    if (!ch_en[i]) state_n = (wrap && !sync) ? S_IDLE : S_DRAIN;
                end
                S_DRAIN: begin
                    cnt_n = (sync || wrap) ? '0 : cnt + DIV_ONE;
                    if (ch_en[i])          state_n = S_RUN;
                    else if (wrap && !sync) state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase

            // The old shadow is what gets applied; a same-cycle write keeps pend set.
            div_act_n = apply ? shadow : div_act;
            shadow_n  = wr_hit ? cfg_div : shadow;
            pend_n    = wr_hit ? 1'b1 : (apply ? 1'b0 : pend);
        end

        // output logic, evaluated on next-state values so the flops line up with cnt
        always_comb begin
            run_n  = (state_n != S_IDLE);
            r_n    = (div_act_n < DIV_TWO) ? DIV_TWO : div_act_n;
            lo_n   = ({1'b0, r_n} + (DIV_W+1)'(1)) >> 1;
            clk_n  = run_n && ({1'b0, cnt_n} >= lo_n);
            tick_n = run_n && (cnt_n == r_n - DIV_ONE);
        end

        assign cfg_pend[i] = pend;
        assign running[i]  = (state != S_IDLE);
        assign clk_out[i]  = clk_q;
        assign tick[i]     = tick_q;
    end

endmodule
